mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/soc_bus_pkg.sv | 27 ++
 rtl/mem_bus_arbiter_if.sv | 46 ++++
 rtl/mmio_addr_decode.sv | 23 ++
 rtl/mem_bus_arbiter.sv | 110 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_bus_pkg.sv
// Shared types and default address map for the two-requester memory bus arbiter.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_BRAM = 2'd1,
    REG_GPIO = 2'd2
  } region_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam logic [31:0] DEF_BRAM_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_BRAM_TOP  = 32'h0000_07FF;
  localparam logic [31:0] DEF_GPIO_BASE = 32'hFFFF_FFF0;
  localparam logic [31:0] DEF_GPIO_TOP  = 32'hFFFF_FFF3;

  // Both bounds are inclusive.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester handshakes, shared slave bus and slave read data for mem_bus_arbiter.
interface mem_bus_arbiter_if;

  logic        m0_req;
  logic        m1_req;
  logic [31:0] m0_addr;
  logic [31:0] m1_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m1_wdata;
  logic        m0_we;
  logic        m1_we;
  logic [3:0]  m0_mask;
  logic [3:0]  m1_mask;

  logic        m0_gnt;
  logic        m1_gnt;
  logic        m0_rvalid;
  logic        m1_rvalid;
  logic [31:0] m0_rdata;
  logic [31:0] m1_rdata;
  logic        bus_err;

  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic [3:0]  byteMask;
  logic [31:0] bramReadData;
  logic [31:0] gpioReadData;

  // Arbiter side.
  modport slave (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
           m0_we, m1_we, m0_mask, m1_mask, bramReadData, gpioReadData,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           bus_err, memAddress, memWriteData, memWrite, byteMask
  );

  // Requester and slave-data side.
  modport master (
    output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
           m0_we, m1_we, m0_mask, m1_mask, bramReadData, gpioReadData,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           bus_err, memAddress, memWriteData, memWrite, byteMask
  );

endinterface

// File: rtl/mmio_addr_decode.sv
// Combinational byte-address to region decode; BRAM takes priority if windows overlap.
module mmio_addr_decode
  import soc_bus_pkg::*;
#(
  parameter logic [31:0] BRAM_BASE = DEF_BRAM_BASE,
  parameter logic [31:0] BRAM_TOP  = DEF_BRAM_TOP,
  parameter logic [31:0] GPIO_BASE = DEF_GPIO_BASE,
  parameter logic [31:0] GPIO_TOP  = DEF_GPIO_TOP
) (
  input  logic [31:0] addr,
  output region_t     region
);

  always_comb begin
    region = REG_NONE;
    if (in_range(addr, BRAM_BASE, BRAM_TOP)) begin
      region = REG_BRAM;
    end else if (in_range(addr, GPIO_BASE, GPIO_TOP)) begin
      region = REG_GPIO;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter giving a CPU (m0) and a loader (m1) two-cycle access to BRAM/GPIO.
// state | meaning
// IDLE  | waiting for a request; grants and drives the bus combinationally
// RESP  | returns slave data / ack to the registered owner
module mem_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter logic [31:0] BRAM_BASE = DEF_BRAM_BASE,
  parameter logic [31:0] BRAM_TOP  = DEF_BRAM_TOP,
  parameter logic [31:0] GPIO_BASE = DEF_GPIO_BASE,
  parameter logic [31:0] GPIO_TOP  = DEF_GPIO_TOP
) (
  input logic              slowed_clk,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);

  state_t      state;
  logic        last_winner;
  logic        owner;
  region_t     region_q;

  logic        winner;
  logic        grant;
  logic        resp;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_we;
  logic [3:0]  sel_mask;
  region_t     sel_region;
  logic [31:0] resp_data;

  // A lone requester always wins; on a tie the one not granted last wins.
  always_comb begin
    winner = bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      winner = ~last_winner;
    end
  end

  // Gated by reset so nothing leaks onto the bus while reset is held.
  assign grant = (state == IDLE) && !reset && (bus.m0_req || bus.m1_req);

  assign sel_addr  = winner ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = winner ? bus.m1_wdata : bus.m0_wdata;
  assign sel_we    = winner ? bus.m1_we    : bus.m0_we;
  assign sel_mask  = winner ? bus.m1_mask  : bus.m0_mask;

  mmio_addr_decode #(
    .BRAM_BASE (BRAM_BASE),
    .BRAM_TOP  (BRAM_TOP),
    .GPIO_BASE (GPIO_BASE),
    .GPIO_TOP  (GPIO_TOP)
  ) u_decode (
    .addr   (sel_addr),
    .region (sel_region)
  );

  assign bus.m0_gnt       = grant && !winner;
  assign bus.m1_gnt       = grant &&  winner;
  assign bus.memAddress   = grant ? sel_addr  : '0;
  assign bus.memWriteData = grant ? sel_wdata : '0;
  assign bus.byteMask     = grant ? sel_mask  : '0;
  // Unmapped writes are still acked but never strobe the bus.
  assign bus.memWrite     = grant && sel_we && (sel_region != REG_NONE);

  always_ff @(posedge slowed_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_winner <= 1'b1;
      owner       <= 1'b0;
      region_q    <= REG_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state       <= RESP;
            last_winner <= winner;
            owner       <= winner;
            region_q    <= sel_region;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign resp = (state == RESP);

  always_comb begin
    resp_data = '0;
    case (region_q)
      REG_BRAM: resp_data = bus.bramReadData;
      REG_GPIO: resp_data = bus.gpioReadData;
      default:  resp_data = '0;
    endcase
  end

  assign bus.m0_rvalid = resp && !owner;
  assign bus.m1_rvalid = resp &&  owner;
  assign bus.m0_rdata  = bus.m0_rvalid ? resp_data : '0;
  assign bus.m1_rdata  = bus.m1_rvalid ? resp_data : '0;
  assign bus.bus_err   = resp && (region_q == REG_NONE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: responses are queued at grant and checked on rvalid.
module tb_mem_bus_arbiter;

  localparam logic [31:0] BRAM_RD = 32'hDEAD_BEEF;
  localparam logic [31:0] GPIO_RD = 32'h1234_5678;

  typedef struct packed {
    logic        owner;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic slowed_clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic exp_last;
  resp_t sb[$];

  mem_bus_arbiter_if bus();

  mem_bus_arbiter dut (
    .slowed_clk (slowed_clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 slowed_clk = ~slowed_clk;

  // 0 = unmapped, 1 = BRAM, 2 = GPIO for the default map.
  function automatic logic [1:0] exp_kind(input logic [31:0] a);
    if (a <= 32'h0000_07FF) return 2'd1;
    if (a >= 32'hFFFF_FFF0 && a <= 32'hFFFF_FFF3) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    case (exp_kind(a))
      2'd1:    return BRAM_RD;
      2'd2:    return GPIO_RD;
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input int who, input logic req, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic we, input logic [3:0] mask);
    if (who == 0) begin
      bus.m0_req = req; bus.m0_addr = addr; bus.m0_wdata = wdata;
      bus.m0_we = we; bus.m0_mask = mask;
    end else begin
      bus.m1_req = req; bus.m1_addr = addr; bus.m1_wdata = wdata;
      bus.m1_we = we; bus.m1_mask = mask;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge slowed_clk); #1;
    @(posedge slowed_clk); #1;
    reset = 1'b0;
    exp_last = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    drive(0, 1'b1, 32'h10, 32'hAAAA_5555, 1'b1, 4'hF);
    drive(1, 1'b1, 32'h20, 32'h5555_AAAA, 1'b1, 4'hF);
    @(negedge slowed_clk);
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.bus_err, bus.memWrite} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt=%b%b rvalid=%b%b err=%b we=%b, expected all 0",
               bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.bus_err, bus.memWrite);
    end
    checks++;
    if (bus.memAddress !== 32'h0 || bus.memWriteData !== 32'h0 || bus.byteMask !== 4'h0 ||
        bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h mask=%h rdata0=%h rdata1=%h, expected 0",
               bus.memAddress, bus.memWriteData, bus.byteMask, bus.m0_rdata, bus.m1_rdata);
    end
    @(posedge slowed_clk); #1;
    reset = 1'b0;
    exp_last = 1'b1;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    @(negedge slowed_clk);
    checks++;
    if (bus.m0_gnt !== 1'b0 || bus.m1_gnt !== 1'b0 || bus.memAddress !== 32'h0 ||
        bus.memWrite !== 1'b0 || bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: gnt=%b%b addr=%h we=%b rvalid=%b%b, expected all 0",
               bus.m0_gnt, bus.m1_gnt, bus.memAddress, bus.memWrite, bus.m0_rvalid, bus.m1_rvalid);
    end
    @(posedge slowed_clk); #1;
  endtask

  // One requester alone: grant cycle then response cycle.
  task automatic test_single_access(input string name, input int who, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic we, input logic [3:0] mask);
    resp_t r;
    logic  mapped;
    logic [31:0] own_rdata, other_rdata;
    mapped = (exp_kind(addr) != 2'd0);
    drive(who, 1'b1, addr, wdata, we, mask);
    @(negedge slowed_clk);
    checks++;
    if (bus.m0_gnt !== (who == 0) || bus.m1_gnt !== (who == 1)) begin
      errors++;
      $display("FAIL %s_gnt: m0_gnt=%b m1_gnt=%b, expected requester %0d only",
               name, bus.m0_gnt, bus.m1_gnt, who);
    end
    checks++;
    if (bus.memAddress !== addr || bus.memWriteData !== wdata || bus.byteMask !== mask) begin
      errors++;
      $display("FAIL %s_bus: addr=%h wdata=%h mask=%h, expected %h %h %h",
               name, bus.memAddress, bus.memWriteData, bus.byteMask, addr, wdata, mask);
    end
    checks++;
    if (bus.memWrite !== (we && mapped)) begin
      errors++;
      $display("FAIL %s_memwrite: got %b, expected %b", name, bus.memWrite, we && mapped);
    end
    sb.push_back('{owner: (who == 1), rdata: exp_rdata(addr), err: !mapped});
    exp_last = (who == 1);
    @(posedge slowed_clk); #1;
    drive(who, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    @(negedge slowed_clk);
    r = sb.pop_front();
    own_rdata   = r.owner ? bus.m1_rdata : bus.m0_rdata;
    other_rdata = r.owner ? bus.m0_rdata : bus.m1_rdata;
    checks++;
    if (bus.m0_gnt !== 1'b0 || bus.m1_gnt !== 1'b0 || bus.memWrite !== 1'b0) begin
      errors++;
      $display("FAIL %s_resp_quiet: gnt=%b%b memWrite=%b, expected 0",
               name, bus.m0_gnt, bus.m1_gnt, bus.memWrite);
    end
    checks++;
    if (bus.m0_rvalid !== !r.owner || bus.m1_rvalid !== r.owner) begin
      errors++;
      $display("FAIL %s_rvalid: m0=%b m1=%b, expected owner %0d only",
               name, bus.m0_rvalid, bus.m1_rvalid, r.owner);
    end
    checks++;
    if (own_rdata !== r.rdata || other_rdata !== 32'h0) begin
      errors++;
      $display("FAIL %s_rdata: owner=%h other=%h, expected %h and 0",
               name, own_rdata, other_rdata, r.rdata);
    end
    checks++;
    if (bus.bus_err !== r.err) begin
      errors++;
      $display("FAIL %s_bus_err: got %b, expected %b", name, bus.bus_err, r.err);
    end
    @(posedge slowed_clk); #1;
  endtask

  task automatic test_boundaries();
    logic [31:0] addrs [7];
    addrs = '{32'h0000_0000, 32'h0000_07FF, 32'h0000_0800, 32'hFFFF_FFEF,
              32'hFFFF_FFF0, 32'hFFFF_FFF3, 32'hFFFF_FFF4};
    for (int i = 0; i < 7; i++) begin
      test_single_access($sformatf("bound%0d", i), i % 2, addrs[i], 32'h0, 1'b0, 4'hF);
    end
  endtask

  task automatic test_round_robin();
    resp_t r;
    logic  w;
    apply_reset();
    drive(0, 1'b1, 32'h0000_0100, 32'h0, 1'b0, 4'hF);
    drive(1, 1'b1, 32'h0000_0104, 32'h0, 1'b0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      @(negedge slowed_clk);
      if (i % 2 == 0) begin
        w = ~exp_last;
        checks++;
        if (bus.m0_gnt !== ~w || bus.m1_gnt !== w) begin
          errors++;
          $display("FAIL rr_grant%0d: m0_gnt=%b m1_gnt=%b, expected requester %0d",
                   i / 2, bus.m0_gnt, bus.m1_gnt, w);
        end
        sb.push_back('{owner: w, rdata: BRAM_RD, err: 1'b0});
        exp_last = w;
      end else begin
        r = sb.pop_front();
        checks++;
        if (bus.m0_gnt !== 1'b0 || bus.m1_gnt !== 1'b0 ||
            bus.m0_rvalid !== !r.owner || bus.m1_rvalid !== r.owner ||
            (r.owner ? bus.m1_rdata : bus.m0_rdata) !== r.rdata) begin
          errors++;
          $display("FAIL rr_resp%0d: gnt=%b%b rvalid=%b%b rdata0=%h rdata1=%h, expected owner %0d data %h",
                   i / 2, bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid,
                   bus.m0_rdata, bus.m1_rdata, r.owner, r.rdata);
        end
      end
      @(posedge slowed_clk); #1;
    end
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    @(negedge slowed_clk);
    if (sb.size() != 0) begin
      r = sb.pop_front();
      checks++;
      if (bus.m0_rvalid !== !r.owner || bus.m1_rvalid !== r.owner) begin
        errors++;
        $display("FAIL rr_tail: rvalid=%b%b, expected owner %0d", bus.m0_rvalid, bus.m1_rvalid, r.owner);
      end
    end
    @(posedge slowed_clk); #1;
    @(posedge slowed_clk); #1;
  endtask

  // A request raised during RESP and dropped before IDLE must leave no trace.
  task automatic test_dropped_req();
    resp_t r;
    drive(0, 1'b1, 32'h0000_0020, 32'h0, 1'b0, 4'hF);
    @(negedge slowed_clk);
    checks++;
    if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL drop_first_gnt: m0_gnt=%b m1_gnt=%b, expected 1 0", bus.m0_gnt, bus.m1_gnt);
    end
    sb.push_back('{owner: 1'b0, rdata: BRAM_RD, err: 1'b0});
    exp_last = 1'b0;
    @(posedge slowed_clk); #1;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    drive(1, 1'b1, 32'h0000_0030, 32'h0, 1'b1, 4'hF);
    @(negedge slowed_clk);
    r = sb.pop_front();
    checks++;
    if (bus.m1_gnt !== 1'b0 || bus.memWrite !== 1'b0 || bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== r.rdata) begin
      errors++;
      $display("FAIL drop_resp: m1_gnt=%b memWrite=%b m0_rvalid=%b rdata=%h, expected 0 0 1 %h",
               bus.m1_gnt, bus.memWrite, bus.m0_rvalid, bus.m0_rdata, r.rdata);
    end
    @(posedge slowed_clk); #1;
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge slowed_clk);
      checks++;
      if (bus.m0_gnt !== 1'b0 || bus.m1_gnt !== 1'b0 || bus.m1_rvalid !== 1'b0 ||
          bus.memAddress !== 32'h0 || bus.memWrite !== 1'b0) begin
        errors++;
        $display("FAIL drop_after%0d: gnt=%b%b m1_rvalid=%b addr=%h we=%b, expected all 0",
                 i, bus.m0_gnt, bus.m1_gnt, bus.m1_rvalid, bus.memAddress, bus.memWrite);
      end
      @(posedge slowed_clk); #1;
    end
  endtask

  task automatic test_reset_in_resp();
    resp_t r;
    logic  w;
    drive(0, 1'b1, 32'h0000_0040, 32'h0, 1'b0, 4'hF);
    @(negedge slowed_clk);
    checks++;
    if (bus.m0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rir_pre_gnt: m0_gnt=%b, expected 1", bus.m0_gnt);
    end
    exp_last = 1'b0;
    @(posedge slowed_clk); #1;
    drive(0, 1'b1, 32'h0000_0044, 32'h0, 1'b0, 4'hF);
    drive(1, 1'b1, 32'h0000_0048, 32'h0, 1'b0, 4'hF);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.m0_rvalid, bus.m1_rvalid, bus.bus_err, bus.m0_gnt, bus.m1_gnt, bus.memWrite} !== 6'b0 ||
        bus.m0_rdata !== 32'h0 || bus.memAddress !== 32'h0 || bus.byteMask !== 4'h0) begin
      errors++;
      $display("FAIL rir_abandon: rvalid=%b%b err=%b gnt=%b%b we=%b rdata=%h addr=%h mask=%h, expected 0",
               bus.m0_rvalid, bus.m1_rvalid, bus.bus_err, bus.m0_gnt, bus.m1_gnt, bus.memWrite,
               bus.m0_rdata, bus.memAddress, bus.byteMask);
    end
    @(negedge slowed_clk);
    checks++;
    if (bus.m0_gnt !== 1'b0 || bus.m1_gnt !== 1'b0 || bus.m0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rir_held: gnt=%b%b m0_rvalid=%b, expected 0", bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid);
    end
    @(posedge slowed_clk); #1;
    reset = 1'b0;
    exp_last = 1'b1;
    sb.delete();
    @(negedge slowed_clk);
    w = ~exp_last;
    checks++;
    if (bus.m0_gnt !== ~w || bus.m1_gnt !== w) begin
      errors++;
      $display("FAIL rir_tie: m0_gnt=%b m1_gnt=%b, expected requester %0d", bus.m0_gnt, bus.m1_gnt, w);
    end
    sb.push_back('{owner: w, rdata: BRAM_RD, err: 1'b0});
    exp_last = w;
    @(posedge slowed_clk); #1;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    @(negedge slowed_clk);
    r = sb.pop_front();
    checks++;
    if (bus.m0_rvalid !== !r.owner || bus.m1_rvalid !== r.owner || bus.m0_rdata !== r.rdata) begin
      errors++;
      $display("FAIL rir_resp: rvalid=%b%b rdata=%h, expected owner %0d data %h",
               bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, r.owner, r.rdata);
    end
    @(posedge slowed_clk); #1;
    @(negedge slowed_clk);
    checks++;
    if (bus.m1_gnt !== 1'b1 || bus.m0_gnt !== 1'b0 || bus.memAddress !== 32'h0000_0048) begin
      errors++;
      $display("FAIL rir_m1_gnt: gnt=%b%b addr=%h, expected 0 1 00000048",
               bus.m0_gnt, bus.m1_gnt, bus.memAddress);
    end
    @(posedge slowed_clk); #1;
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    @(posedge slowed_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    exp_last = 1'b1;
    bus.bramReadData = BRAM_RD;
    bus.gpioReadData = GPIO_RD;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    test_reset();
    test_single_access("read_bram", 0, 32'h0000_0010, 32'h0, 1'b0, 4'hF);
    test_single_access("gpio_write", 1, 32'hFFFF_FFF0, 32'h0000_0001, 1'b1, 4'b0001);
    test_single_access("unmapped_write", 0, 32'h0000_0800, 32'hCAFE_F00D, 1'b1, 4'hF);
    test_single_access("bram_write", 1, 32'h0000_07FC, 32'h0BAD_F00D, 1'b1, 4'b1100);
    test_boundaries();
    test_round_robin();
    test_dropped_req();
    test_reset_in_resp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
